round_sequencer: RTL and testbench

//  Sequences each tug-of-war round and drives the scorer's right/leds_on/winrnd inputs.

---
 rtl/tow_pkg.sv | 27 ++
 rtl/tow_lfsr.sv | 31 +++
 rtl/round_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_round_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// Shared tug-of-war definitions: sequencer state encoding, scorer terminal
// patterns and the start-light LFSR seed.
package tow_pkg;

    // Round sequencer states
    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWait     = 3'd1,
        StLight    = 3'd2,
        StJudge    = 3'd3,
        StGameOver = 3'd4
    } state_e;

    // Scorer patterns that end the game: left win, right win, error
    localparam logic [6:0] SCORE_WL  = 7'b1110000;
    localparam logic [6:0] SCORE_WR  = 7'b0000111;
    localparam logic [6:0] SCORE_ERR = 7'b1010101;

    // LFSR reset value; must be non-zero or the register locks up
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // True when the scorer shows a pattern that freezes the game
    function automatic logic is_final_score(input logic [6:0] s);
        return (s == SCORE_WL) || (s == SCORE_WR) || (s == SCORE_ERR);
    endfunction

endpackage

// File: rtl/tow_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
// Shifts every clock cycle; supplies the random start-light delay.
module tow_lfsr
    import tow_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] lfsr_q, lfsr_d;
    logic        feedback;

    // Next state: shift left, feed the XOR of the tap bits into bit 0
    always_comb begin
        feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d   = {lfsr_q[14:0], feedback};
    end

    // Register with seed on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/round_sequencer.sv
// Tug-of-war round sequencer. Waits for both buttons released, holds a random
// delay, lights the start LEDs, arbitrates the first push and pulses winrnd
// toward the scorer. Freezes in game-over when the scorer shows a final pattern.
// Optional feature: define ROUND_TIMEOUT_EN to void a round when nobody pushes
// within TIMEOUT_CYC cycles of the LEDs lighting.
module round_sequencer
    import tow_pkg::*;
#(
    parameter int unsigned DLY_MIN     = 16,
    parameter int unsigned DLY_BITS    = 8,
    parameter int unsigned RELEASE_CYC = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb_l,
    input  logic       pb_r,
    input  logic [6:0] score,
    output logic       leds_on,
    output logic       winrnd,
    output logic       right,
    output logic       game_over
);

    // Counter widths sized so the largest loaded value always fits
    localparam int unsigned DlyW = $clog2(DLY_MIN + (1 << DLY_BITS));
    localparam int unsigned RelW = $clog2(RELEASE_CYC + 1);

    state_e          state_q, state_d;
    logic [RelW-1:0] rel_cnt_q, rel_cnt_d;
    logic [DlyW-1:0] dly_cnt_q, dly_cnt_d;
    logic            tie_pri_q, tie_pri_d;
    logic            leds_on_q, leds_on_d;
    logic            winrnd_q, winrnd_d;
    logic            right_q, right_d;
    logic            game_over_q, game_over_d;

    logic [15:0]     lfsr_q;
    logic [DlyW-1:0] dly_load;
    logic            push;
    logic            tie;
    logic            push_right;
    logic            timeout;
    logic            unused_lfsr;

    tow_lfsr u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Only the low DLY_BITS of the LFSR feed the delay
    assign unused_lfsr = ^lfsr_q;
    assign dly_load    = DlyW'(DLY_MIN) + DlyW'(lfsr_q[DLY_BITS-1:0]);

`ifdef ROUND_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);

    logic [ToW-1:0] to_cnt_q, to_cnt_d;

    // Count cycles spent in LIGHT; cleared in every other state
    always_comb begin
        to_cnt_d = '0;
        if (state_q == StLight) begin
            to_cnt_d = to_cnt_q + ToW'(1);
        end
    end

    // Timeout counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign timeout = (state_q == StLight) && (to_cnt_q == ToW'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;

    // LIGHT waits forever without the timeout feature
    assign timeout        = 1'b0;
    assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

    // Next-state and next-output logic for the round FSM and arbiter
    always_comb begin
        state_d     = state_q;
        rel_cnt_d   = rel_cnt_q;
        dly_cnt_d   = dly_cnt_q;
        tie_pri_d   = tie_pri_q;
        leds_on_d   = 1'b0;
        winrnd_d    = 1'b0;
        right_d     = 1'b0;
        game_over_d = 1'b0;

        push       = pb_l | pb_r;
        tie        = pb_l & pb_r;
        push_right = tie ? tie_pri_q : pb_r;

        unique case (state_q)
            StIdle: begin
                if (is_final_score(score)) begin
                    state_d     = StGameOver;
                    game_over_d = 1'b1;
                end else if (push) begin
                    // Any press restarts the release window
                    rel_cnt_d = '0;
                end else if (rel_cnt_q == RelW'(RELEASE_CYC - 1)) begin
                    state_d   = StWait;
                    rel_cnt_d = '0;
                    dly_cnt_d = dly_load;
                end else begin
                    rel_cnt_d = rel_cnt_q + RelW'(1);
                end
            end

            StWait: begin
                if (push) begin
                    // Jumped the light: judged with LEDs still dark
                    state_d  = StJudge;
                    winrnd_d = 1'b1;
                    right_d  = push_right;
                    if (tie) begin
                        tie_pri_d = ~tie_pri_q;
                    end
                end else if (dly_cnt_q == '0) begin
                    state_d   = StLight;
                    leds_on_d = 1'b1;
                end else begin
                    dly_cnt_d = dly_cnt_q - DlyW'(1);
                end
            end

            StLight: begin
                leds_on_d = 1'b1;
                if (push) begin
                    state_d  = StJudge;
                    winrnd_d = 1'b1;
                    right_d  = push_right;
                    if (tie) begin
                        tie_pri_d = ~tie_pri_q;
                    end
                end else if (timeout) begin
                    // Void round: back to IDLE without a winrnd pulse
                    state_d   = StIdle;
                    leds_on_d = 1'b0;
                end
            end

            StJudge: begin
                state_d = StIdle;
            end

            StGameOver: begin
                game_over_d = 1'b1;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rel_cnt_q   <= '0;
            dly_cnt_q   <= '0;
            tie_pri_q   <= 1'b0;
            leds_on_q   <= 1'b0;
            winrnd_q    <= 1'b0;
            right_q     <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rel_cnt_q   <= rel_cnt_d;
            dly_cnt_q   <= dly_cnt_d;
            tie_pri_q   <= tie_pri_d;
            leds_on_q   <= leds_on_d;
            winrnd_q    <= winrnd_d;
            right_q     <= right_d;
            game_over_q <= game_over_d;
        end
    end

    assign leds_on   = leds_on_q;
    assign winrnd    = winrnd_q;
    assign right     = right_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Self-checking bench for round_sequencer. Predicts the cycle of every
// LED-on, judge and game-over event from edge counts and a reference LFSR.
module tb_round_sequencer;

    localparam int DLY_MIN     = 16;
    localparam int DLY_BITS    = 8;
    localparam int RELEASE_CYC = 4;
    localparam int TIMEOUT_CYC = 1024;

    localparam logic [6:0] SC_N  = 7'b0001000;
    localparam logic [6:0] SC_WR = 7'b0000111;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       pb_l  = 1'b0;
    logic       pb_r  = 1'b0;
    logic [6:0] score = SC_N;
    logic       leds_on;
    logic       winrnd;
    logic       right;
    logic       game_over;

    int cyc;
    int n_pass   = 0;
    int n_checks = 0;
    int idle_first;  // first edge evaluated in IDLE
    int rel_first;   // first edge of the current all-released streak
    bit tie_pri_m;

    round_sequencer #(
        .DLY_MIN     (DLY_MIN),
        .DLY_BITS    (DLY_BITS),
        .RELEASE_CYC (RELEASE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pb_l      (pb_l),
        .pb_r      (pb_r),
        .score     (score),
        .leds_on   (leds_on),
        .winrnd    (winrnd),
        .right     (right),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    // Edges since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int btn);
        pb_l = (btn == 1) || (btn == 3);
        pb_r = (btn == 2) || (btn == 3);
    endtask

    // Seed stepped n times through x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_after(input int n);
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < n; i++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        return s;
    endfunction

    // Arm edge and LED-on edge of the coming round
    task automatic predict(output int arm, output int light);
        logic [15:0] v;
        int d;
        arm   = ((idle_first > rel_first) ? idle_first : rel_first) + RELEASE_CYC - 1;
        v     = lfsr_after(arm - 1);
        d     = DLY_MIN + (int'(v) % (1 << DLY_BITS));
        light = arm + 1 + d;
    endtask

    task automatic wait_until(input int e, input logic exp_led);
        while (cyc < e) begin
            tick();
            check("leds_level", leds_on, exp_led);
            check("no_winrnd", winrnd, 1'b0);
        end
    endtask

    task automatic reach_light(output int light);
        int arm;
        predict(arm, light);
        wait_until(light - 1, 1'b0);
        tick();
        check("light_on", leds_on, 1'b1);
        check("light_no_winrnd", winrnd, 1'b0);
    endtask

    // kind 0: push after light; kind 1: push during the delay.
    // btn 1 = left, 2 = right, 3 = both. hold = extra cycles kept pressed.
    task automatic play_round(input int kind, input int btn, input int hold);
        int arm, light, p;
        logic exp_r, exp_led;
        if (kind == 1) begin
            predict(arm, light);
            p = arm + 1 + int'($urandom_range(0, light - arm - 1));
            wait_until(p - 1, 1'b0);
            exp_led = 1'b0;
        end else begin
            reach_light(light);
            p = light + 1 + int'($urandom_range(0, 4));
            wait_until(p - 1, 1'b1);
            exp_led = 1'b1;
        end
        press(btn);
        if (btn == 3) begin
            exp_r     = tie_pri_m;
            tie_pri_m = ~tie_pri_m;
        end else begin
            exp_r = (btn == 2);
        end
        tick();
        check("winrnd_pulse", winrnd, 1'b1);
        check("right", right, exp_r);
        check("leds_at_judge", leds_on, exp_led);
        tick();
        check("winrnd_end", winrnd, 1'b0);
        check("leds_after", leds_on, 1'b0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("held_winrnd", winrnd, 1'b0);
            check("held_leds", leds_on, 1'b0);
        end
        press(0);
        idle_first = p + 2;
        rel_first  = cyc + 1;
    endtask

    task automatic reset_dut();
        press(0);
        score = SC_N;
        rst   = 1'b1;
        #1;
        check("rst_leds", leds_on, 1'b0);
        check("rst_winrnd", winrnd, 1'b0);
        check("rst_right", right, 1'b0);
        check("rst_game_over", game_over, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        idle_first = 1;
        rel_first  = 1;
        tie_pri_m  = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int light;
        #2;
        reset_dut();

        // Exact first light, then a right push after light
        play_round(0, 2, 0);
        // Left jumps the light
        play_round(1, 1, 0);
        // Two ties in a row alternate left then right
        play_round(0, 3, 0);
        play_round(1, 3, 0);
        // Right held long after the judge
        play_round(0, 2, 8);

        for (int r = 0; r < 30; r++) begin
            play_round(int'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
                       int'($urandom_range(0, 6)));
        end

        // Reset mid-round with the LEDs lit
        reach_light(light);
        reset_dut();
        play_round(0, 3, 0);

`ifdef ROUND_TIMEOUT_EN
        reach_light(light);
        wait_until(light + TIMEOUT_CYC - 1, 1'b1);
        tick();
        check("timeout_leds", leds_on, 1'b0);
        check("timeout_winrnd", winrnd, 1'b0);
        idle_first = light + TIMEOUT_CYC + 1;
        play_round(0, 1, 0);
`endif

        // Game over from IDLE; pushes ignored; only reset leaves
        play_round(0, 1, 0);
        score = SC_WR;
        tick();
        check("go_set", game_over, 1'b1);
        check("go_leds", leds_on, 1'b0);
        press(3);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("go_winrnd", winrnd, 1'b0);
            check("go_hold", game_over, 1'b1);
        end
        press(0);
        score = SC_N;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("go_frozen", game_over, 1'b1);
            check("go_dark", leds_on, 1'b0);
        end
        reset_dut();
        play_round(1, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
